// File: rtl/count_bcd_conv.sv
// Sequential binary-to-BCD converter for the frequency counter readout.
// Uses double-dabble over WIDTH cycles, then publishes the BCD result and its significant digit count.
module count_bcd_conv #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      countIn,
    input  logic                  start,
    output logic [4*DIGITS-1:0]   bcdOut,
    output logic [3:0]            digits,
    output logic                  valid,
    output logic                  busy,
    output logic                  missed
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state;
    logic [WIDTH-1:0]    shiftReg;
    logic [4*DIGITS-1:0] acc;
    logic [4*DIGITS-1:0] accNext;
    logic [CW-1:0]       shiftCnt;
    logic [3:0]          accDigits;
    logic [3:0]          adj;
    logic                carry;

    // One double-dabble step: add 3 to digits >= 5, then shift left, with
    // each digit's old MSB carried into the next digit up.
    always_comb begin
        accNext = '0;
        adj     = '0;
        carry   = shiftReg[WIDTH-1];
        for (int i = 0; i < DIGITS; i++) begin
            adj = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
            accNext[4*i +: 4] = {adj[2:0], carry};
            carry = adj[3];
        end
    end

    // Position of the most significant nonzero digit; zero reads as one digit.
    always_comb begin
        accDigits = 4'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] != 4'd0) begin
                accDigits = 4'(i + 1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            shiftReg <= '0;
            acc      <= '0;
            shiftCnt <= '0;
            bcdOut   <= '0;
            digits   <= 4'd1;
            valid    <= 1'b0;
            busy     <= 1'b0;
            missed   <= 1'b0;
        end else begin
            valid <= 1'b0;
            // A start arriving mid-conversion is dropped but remembered until reset.
            if (start && (state != IDLE)) begin
                missed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        shiftReg <= countIn;
                        acc      <= '0;
                        shiftCnt <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc      <= accNext;
                    shiftReg <= shiftReg << 1;
                    shiftCnt <= shiftCnt + CW'(1);
                    if (shiftCnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcdOut <= acc;
                    digits <= accDigits;
                    valid  <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_bcd_conv.sv
// Directed and randomized checks of count_bcd_conv against a decimal-arithmetic reference.
// Each transaction window records every valid pulse so latency, pulse count and results can be checked.
module tb_count_bcd_conv;

    logic        clock;
    logic        reset;
    logic [31:0] countIn;
    logic        start;
    logic [39:0] bcdOut;
    logic [3:0]  digits;
    logic        valid;
    logic        busy;
    logic        missed;

    int errors = 0;
    int checks = 0;

    logic [39:0] validBcd[$];
    logic [3:0]  validDig[$];
    int          validAt[$];
    int          busyCycles;

    count_bcd_conv #(.WIDTH(32), .DIGITS(10)) dut (
        .clock  (clock),
        .reset  (reset),
        .countIn(countIn),
        .start  (start),
        .bcdOut (bcdOut),
        .digits (digits),
        .valid  (valid),
        .busy   (busy),
        .missed (missed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Decimal digits of v, least significant first, by repeated division.
    function automatic logic [39:0] bcdRef(input logic [31:0] v);
        logic [39:0] r;
        longint      x;
        r = '0;
        x = longint'(v);
        for (int d = 0; d < 10; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] digitsRef(input logic [31:0] v);
        longint x;
        int     n;
        x = longint'(v);
        n = 1;
        while (x >= 10) begin
            x = x / 10;
            n++;
        end
        return 4'(n);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pulse start with v1 at cycle 0, optionally a second start or a reset
    // at given cycles, and record everything that happens for 'cycles' cycles.
    task automatic applyStimulus(input logic [31:0] v1, input int start2At, input logic [31:0] v2,
                                 input int resetAt, input int cycles);
        validBcd.delete();
        validDig.delete();
        validAt.delete();
        busyCycles = 0;
        countIn = v1;
        start   = 1'b1;
        for (int n = 1; n <= cycles; n++) begin
            @(negedge clock);
            start   = 1'b0;
            reset   = 1'b0;
            countIn = $urandom();
            if (valid) begin
                validBcd.push_back(bcdOut);
                validDig.push_back(digits);
                validAt.push_back(n);
            end
            if (busy) busyCycles++;
            if (n == start2At) begin
                countIn = v2;
                start   = 1'b1;
            end
            if (n == resetAt) reset = 1'b1;
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic checkSingle(input string tag, input logic [31:0] v);
        checkOutput({tag, " pulses"}, 64'(validBcd.size()), 64'd1);
        checkOutput({tag, " latency"}, validAt.size() > 0 ? 64'(validAt[0]) : 64'hdead, 64'd34);
        checkOutput({tag, " bcd"}, validBcd.size() > 0 ? 64'(validBcd[0]) : 64'hx, 64'(bcdRef(v)));
        checkOutput({tag, " digits"}, validDig.size() > 0 ? 64'(validDig[0]) : 64'hx, 64'(digitsRef(v)));
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        logic [31:0] v;
        reset   = 1'b1;
        start   = 1'b0;
        countIn = '0;
        repeat (3) @(negedge clock);
        checkOutput("reset bcdOut", 64'(bcdOut), 64'd0);
        checkOutput("reset digits", 64'(digits), 64'd1);
        checkOutput("reset valid", 64'(valid), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset missed", 64'(missed), 64'd0);

        // Start coincident with reset must not launch a conversion.
        countIn = 32'd123;
        start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("start under reset busy", 64'(busy), 64'd0);
        checkOutput("start under reset missed", 64'(missed), 64'd0);

        $display("[TB] zero, 1000 and full-scale conversions");
        applyStimulus(32'd0, 0, 32'd0, 0, 36);
        checkSingle("zero", 32'd0);
        applyStimulus(32'd1000, 0, 32'd0, 0, 36);
        checkSingle("1000", 32'd1000);
        checkOutput("1000 bcd const", validBcd.size() > 0 ? 64'(validBcd[0]) : 64'hx, 64'h0000001000);
        checkOutput("1000 busy cycles", 64'(busyCycles), 64'd33);
        checkOutput("1000 hold bcdOut", 64'(bcdOut), 64'h0000001000);
        applyStimulus(32'hFFFFFFFF, 0, 32'd0, 0, 36);
        checkSingle("max", 32'hFFFFFFFF);
        checkOutput("max bcd const", validBcd.size() > 0 ? 64'(validBcd[0]) : 64'hx, 64'h4294967295);
        checkOutput("no missed yet", 64'(missed), 64'd0);

        $display("[TB] dropped start during conversion");
        applyStimulus(32'd50, 10, 32'd99, 0, 50);
        checkSingle("drop", 32'd50);
        checkOutput("drop missed", 64'(missed), 64'd1);
        applyStimulus(32'd3, 0, 32'd0, 0, 36);
        checkOutput("missed sticky", 64'(missed), 64'd1);
        doReset();
        checkOutput("missed cleared", 64'(missed), 64'd0);

        $display("[TB] reset aborts a conversion");
        applyStimulus(32'd12345, 0, 32'd0, 15, 45);
        checkOutput("abort pulses", 64'(validBcd.size()), 64'd0);
        checkOutput("abort bcdOut", 64'(bcdOut), 64'd0);
        checkOutput("abort digits", 64'(digits), 64'd1);
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort missed", 64'(missed), 64'd0);
        applyStimulus(32'd7, 0, 32'd0, 0, 36);
        checkSingle("after abort", 32'd7);

        $display("[TB] back-to-back starts at minimum spacing");
        applyStimulus(32'd9, 34, 32'd10, 0, 72);
        checkOutput("b2b pulses", 64'(validBcd.size()), 64'd2);
        checkOutput("b2b first at", validAt.size() > 0 ? 64'(validAt[0]) : 64'hdead, 64'd34);
        checkOutput("b2b second at", validAt.size() > 1 ? 64'(validAt[1]) : 64'hdead, 64'd68);
        checkOutput("b2b first bcd", validBcd.size() > 0 ? 64'(validBcd[0]) : 64'hx, 64'h09);
        checkOutput("b2b second bcd", validBcd.size() > 1 ? 64'(validBcd[1]) : 64'hx, 64'h10);
        checkOutput("b2b second digits", validDig.size() > 1 ? 64'(validDig[1]) : 64'hx, 64'd2);
        checkOutput("b2b missed", 64'(missed), 64'd0);

        $display("[TB] randomized conversions");
        for (int r = 0; r < 12; r++) begin
            if (r % 3 == 0) v = $urandom_range(0, 999);
            else if (r % 3 == 1) v = $urandom_range(0, 9999999);
            else v = $urandom();
            applyStimulus(v, 0, 32'd0, 0, 36);
            checkSingle($sformatf("rand%0d", r), v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/count_bcd_conv.md
COUNT_BCD_CONV -- requirements
Module: count_bcd_conv

Interface
REQ-001 Parameter WIDTH, default 32: width of the binary count input.
REQ-002 Parameter DIGITS, default 10: number of BCD output digits; 10^DIGITS SHALL exceed 2^WIDTH-1.
REQ-003 clock  input  1  single clock; all state SHALL change only on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 countIn  input  WIDTH  final unsigned count from the frequency counter stage.
REQ-006 start  input  1  one-cycle pulse marking countIn as final (end of gate window).
REQ-007 bcdOut  output  4*DIGITS  packed BCD result; digit 0 in bits [3:0], least significant digit.
REQ-008 digits  output  4  count of significant digits in bcdOut, range 1..DIGITS.
REQ-009 valid  output  1  one-cycle pulse when bcdOut/digits update.
REQ-010 busy  output  1  high while a conversion is in progress.
REQ-011 missed  output  1  sticky flag: a start was dropped.

Function
REQ-012 The block SHALL implement states IDLE, SHIFT, DONE.
REQ-013 IDLE: on a clock edge with start=1, the block SHALL capture countIn into an internal shift register, clear the BCD accumulator and the shift counter, and enter SHIFT.
REQ-014 SHIFT: each cycle, every accumulator digit >=5 SHALL first be incremented by 3, then {accumulator, shift register} SHALL shift left one bit, and the shift counter SHALL increment.
REQ-015 After exactly WIDTH shifts, the block SHALL enter DONE.
REQ-016 DONE: the block SHALL load bcdOut and digits from the accumulator, assert valid for that one cycle, and return to IDLE.
REQ-017 Latency: with start sampled at edge k, valid SHALL be high in the cycle after edge k+WIDTH+1, i.e. 33 cycles for WIDTH=32.
REQ-018 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-019 bcdOut and digits SHALL hold their last values between conversions and change only in DONE.
REQ-020 digits SHALL equal the position (1-based) of the most significant nonzero digit; a zero result SHALL give digits=1.
REQ-021 A start asserted in SHIFT or DONE SHALL be ignored for conversion, SHALL NOT disturb the conversion in progress, and SHALL set missed=1.
REQ-022 missed SHALL stay 1 until reset.
REQ-023 Minimum spacing between accepted start pulses SHALL be WIDTH+2 cycles; countIn SHALL be sampled only at the accepting edge, so later countIn changes are don't-care.
REQ-024 All digit arithmetic SHALL be 4-bit unsigned; no digit of the accumulator SHALL exceed 9 after any shift.
REQ-025 start held high continuously SHALL start one conversion from IDLE, then immediately another on return to IDLE, setting missed while busy.

Reset
REQ-026 With reset=1 at a clock edge, state SHALL become IDLE, and bcdOut=0, digits=1, valid=0, busy=0, missed=0.
REQ-027 reset SHALL take priority over start and over any conversion in progress; an aborted conversion SHALL produce no valid pulse.
REQ-028 A start coincident with reset SHALL be ignored.

Verification
REQ-029 countIn=0, start pulse -> 33 cycles later valid=1, bcdOut=0x0000000000, digits=1.
REQ-030 countIn=1000 (gate-window count for a 1 kHz input over 1 s) -> bcdOut=0x0000001000, digits=4, busy high for exactly 33 cycles.
REQ-031 countIn=4294967295 -> bcdOut=0x4294967295, digits=10.
REQ-032 countIn=50, start; second start 10 cycles later with countIn=99 -> single valid with bcdOut=0x0000000050, missed=1.
REQ-033 countIn=12345, start; reset pulsed at cycle 15 -> no valid, bcdOut=0, busy=0, missed=0; new start with 7 -> bcdOut=0x0000000007, digits=1.
REQ-034 Back-to-back starts spaced exactly 34 cycles with 9 then 10 -> two valid pulses, bcdOut 0x09 then 0x10, missed=0.
